sram_like_bridge: RTL



---
 rtl/sram_like_bridge_if.sv | 45 ++++
 rtl/sram_like_bridge.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sram_like_bridge_if.sv
// ---------------------------------------------------------------------------
// sram_like_bridge_if
// Groups the CPU-side SRAM signals and the sram-like bus signals handled by
// sram_like_bridge.
//   CPU side : sram_en, sram_wen, sram_addr, sram_wdata -> bridge
//              sram_rdata, stall                        <- bridge
//   Bus side : req, wr, size, addr, wdata               <- bridge
//              addr_ok, data_ok, rdata                  -> bridge
// modport master : the bridge's view (drives the bus, answers the CPU)
// modport slave  : the environment's view (CPU plus sram-like target)
// ---------------------------------------------------------------------------
interface sram_like_bridge_if #(
    parameter int unsigned ADDR_W = 32
);
    // CPU side
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;
    logic              stall;
    // sram-like side
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    modport master (
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        input  addr_ok, data_ok, rdata,
        output sram_rdata, stall,
        output req, wr, size, addr, wdata
    );

    modport slave (
        output sram_en, sram_wen, sram_addr, sram_wdata,
        output addr_ok, data_ok, rdata,
        input  sram_rdata, stall,
        input  req, wr, size, addr, wdata
    );
endinterface

// File: rtl/sram_like_bridge.sv
// ---------------------------------------------------------------------------
// sram_like_bridge
// Converts a CPU SRAM-style access (en/wen/addr/wdata) into a split
// address/data sram-like transaction and stalls the CPU until it completes.
// Ports:
//   clk           : sole clock, rising edge
//   rst           : synchronous active-high reset
//   bus           : sram_like_bridge_if.master (CPU side + sram-like side)
//   longest_stall : global pipeline stall, holds the DONE state
//   timeout_err   : sticky watchdog flag, set after TIMEOUT WAIT cycles
// Parameters:
//   ADDR_W    : address width of both sides
//   TIMEOUT   : WAIT cycles before timeout_err sets, 0 disables the watchdog
//   RDATA_RST : reset value of the read-data hold register
// ---------------------------------------------------------------------------
module sram_like_bridge #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] RDATA_RST = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    sram_like_bridge_if.master  bus,
    input  logic                longest_stall,
    output logic                timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr_q, wr_d;     // direction of the transaction in flight
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             wr_c;
    logic [1:0]       size_c;
    logic [1:0]       lo_c;
    logic             req_c;

    // Byte-enable decode: size and low address bits for the bus.
    always_comb begin
        wr_c   = |bus.sram_wen;
        size_c = 2'd2;
        lo_c   = 2'b00;
        if (!wr_c) begin
            lo_c = bus.sram_addr[1:0];
        end else begin
            case (bus.sram_wen)
                4'b0011: begin size_c = 2'd1; lo_c = 2'b00; end
                4'b1100: begin size_c = 2'd1; lo_c = 2'b10; end
                4'b0001: begin size_c = 2'd0; lo_c = 2'b00; end
                4'b0010: begin size_c = 2'd0; lo_c = 2'b01; end
                4'b0100: begin size_c = 2'd0; lo_c = 2'b10; end
                4'b1000: begin size_c = 2'd0; lo_c = 2'b11; end
                default: begin size_c = 2'd2; lo_c = 2'b00; end
            endcase
        end
    end

    assign req_c = (state_q == S_IDLE) && bus.sram_en;

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                // data_ok without an accepted address is ignored here.
                if (req_c && bus.addr_ok) begin
                    wr_d = wr_c;
                    if (bus.data_ok) begin
                        state_d = S_DONE;
                        if (!wr_c) rdata_d = bus.rdata;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if ((TIMEOUT != 0) && (cnt_d == CNT_MAX)) err_d = 1'b1;
                if (bus.data_ok) begin
                    state_d = S_DONE;
                    if (!wr_q) rdata_d = bus.rdata;
                end
            end
            S_DONE: begin
                if (!longest_stall) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdata_q <= RDATA_RST;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.req        = req_c;
    assign bus.wr         = wr_c;
    assign bus.size       = size_c;
    assign bus.addr       = {bus.sram_addr[ADDR_W-1:2], lo_c};
    assign bus.wdata      = bus.sram_wdata;
    assign bus.stall      = bus.sram_en && (state_q != S_DONE);
    assign bus.sram_rdata = rdata_q;
    assign timeout_err    = err_q;

endmodule
